// File: rtl/fib_engine_if.sv
// rtl/fib_engine_if.sv - start/done request bus between a controller and fib_engine
//
// Purpose: groups the request strobe/operands and the completion outputs of
// the Fibonacci engine so that a controller and the engine connect through
// one port.
//
// Signals:
//   start    controller -> engine  request strobe
//   nth      controller -> engine  term count n (N_W bits)
//   mode     controller -> engine  0 = F(n), 1 = S(n) = F(1)+...+F(n)
//   busy     engine -> controller  request in progress
//   result   engine -> controller  last completed result (DATA_W bits)
//   out_en   engine -> controller  one-cycle completion pulse
//   overflow engine -> controller  true value of last result exceeded 2^DATA_W-1
//
// Modports: master (controller side), slave (engine side).

interface fib_engine_if #(
  parameter int DATA_W = 20,
  parameter int N_W    = 8
);
  logic              start;
  logic [N_W-1:0]    nth;
  logic              mode;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              out_en;
  logic              overflow;

  modport master (
    output start, nth, mode,
    input  busy, result, out_en, overflow
  );

  modport slave (
    input  start, nth, mode,
    output busy, result, out_en, overflow
  );
endinterface

// File: rtl/fib_engine.sv
// rtl/fib_engine.sv - iterative Fibonacci term / prefix-sum engine with overflow flag
//
// Purpose: on an accepted start, iterates the Fibonacci recurrence n times
// (one step per cycle) and returns either F(n) or S(n) = F(1)+...+F(n),
// together with a flag telling whether the true value exceeded 2^DATA_W-1.
// Latency from accept to out_en is n+1 cycles.
//
// Parameters:
//   DATA_W  result/accumulator width (>= 2)
//   N_W     width of the nth operand
//
// Ports:
//   clk     single clock, rising edge
//   reset   synchronous, active-high
//   bus     fib_engine_if.slave (start/nth/mode in; busy/result/out_en/overflow out)
//
// Build option:
//   FIB_SATURATE_EN  defined   -> a1/acc clamp to all-ones once they overflow
//                    undefined -> arithmetic wraps modulo 2^DATA_W

module fib_engine #(
  parameter int DATA_W = 20,
  parameter int N_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  fib_engine_if.slave  bus
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t state, state_nxt;

  logic [N_W-1:0]    cnt;
  logic              mode_q;
  logic [DATA_W-1:0] a0, a1, acc;
  logic              ovf_a0, ovf_a1, ovf_acc;
  logic [DATA_W-1:0] result_q;
  logic              out_en_q;
  logic              overflow_q;

  // Control strobes decoded from the state (output process).
  logic busy;
  logic load;
  logic step;
  logic done;

  // Iteration datapath: carries come from the extra top bit of each sum.
  logic [DATA_W:0]   sum_a, sum_acc;
  logic              ovf_a1_nxt, ovf_acc_nxt;
  logic [DATA_W-1:0] a1_nxt, acc_nxt;

  assign sum_a   = {1'b0, a0}  + {1'b0, a1};
  assign sum_acc = {1'b0, acc} + {1'b0, a1};

  // Flags are sticky: once a term has overflowed, every later term and every
  // later prefix sum has overflowed as well.
  assign ovf_a1_nxt  = ovf_a1 | sum_a[DATA_W];
  assign ovf_acc_nxt = ovf_acc | sum_acc[DATA_W] | ovf_a1;

`ifdef FIB_SATURATE_EN
  assign a1_nxt  = ovf_a1_nxt  ? {DATA_W{1'b1}} : sum_a[DATA_W-1:0];
  assign acc_nxt = ovf_acc_nxt ? {DATA_W{1'b1}} : sum_acc[DATA_W-1:0];
`else
  assign a1_nxt  = sum_a[DATA_W-1:0];
  assign acc_nxt = sum_acc[DATA_W-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start)      state_nxt = CALC;
      CALC: if (cnt == '0)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: load = bus.start;
      CALC: begin
        busy = 1'b1;
        step = (cnt != '0);
        done = (cnt == '0);
      end
      default: ;
    endcase
  end

  // Datapath and registered completion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      mode_q     <= 1'b0;
      a0         <= '0;
      a1         <= '0;
      acc        <= '0;
      ovf_a0     <= 1'b0;
      ovf_a1     <= 1'b0;
      ovf_acc    <= 1'b0;
      result_q   <= '0;
      out_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_en_q <= 1'b0;
      if (load) begin
        cnt     <= bus.nth;
        mode_q  <= bus.mode;
        a0      <= '0;
        a1      <= {{(DATA_W-1){1'b0}}, 1'b1};
        acc     <= '0;
        ovf_a0  <= 1'b0;
        ovf_a1  <= 1'b0;
        ovf_acc <= 1'b0;
      end
      if (step) begin
        a0      <= a1;
        a1      <= a1_nxt;
        acc     <= acc_nxt;
        cnt     <= cnt - N_W'(1);
        ovf_a0  <= ovf_a1;
        ovf_a1  <= ovf_a1_nxt;
        ovf_acc <= ovf_acc_nxt;
      end
      if (done) begin
        result_q   <= mode_q ? acc : a0;
        overflow_q <= mode_q ? ovf_acc : ovf_a0;
        out_en_q   <= 1'b1;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.result   = result_q;
  assign bus.out_en   = out_en_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fib_engine.sv
// tb/tb_fib_engine.sv - self-checking bench for fib_engine (20/8 and 8/4 instances)

module tb_fib_engine;

`ifdef FIB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int TIMEOUT = 400;

  logic clk;
  logic reset;

  fib_engine_if #(.DATA_W(20), .N_W(8)) b20();
  fib_engine_if #(.DATA_W(8),  .N_W(4)) b8();

  fib_engine #(.DATA_W(20), .N_W(8)) u20 (.clk(clk), .reset(reset), .bus(b20));
  fib_engine #(.DATA_W(8),  .N_W(4)) u8  (.clk(clk), .reset(reset), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int     which;   // 0 = 20/8 instance, 1 = 8/4 instance
    int     n;
    bit     m;
    longint res;
    bit     ovf;
    int     lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic get_oe(input int which);
    return (which == 0) ? b20.out_en : b8.out_en;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 0) ? b20.busy : b8.busy;
  endfunction

  function automatic longint get_res(input int which);
    return (which == 0) ? longint'(b20.result) : longint'(b8.result);
  endfunction

  function automatic logic get_ovf(input int which);
    return (which == 0) ? b20.overflow : b8.overflow;
  endfunction

  // Reference: F and S reduced mod 2^w, plus the true values capped at 2^w
  // (capping keeps "exceeds 2^w-1" exact because the sequences never shrink).
  task automatic ref_model(input int w, input int n, input bit m,
                           output longint res, output bit ovf);
    longint mask, lim, f0, f1, s, c0, c1, cs, t, tv;
    mask = (64'd1 << w) - 1;
    lim  = 64'd1 << w;
    f0 = 0; f1 = 1; s = 0;
    c0 = 0; c1 = 1; cs = 0;
    for (int k = 1; k <= n; k++) begin
      s  = (s + f1) & mask;
      cs = (cs + c1 > lim) ? lim : cs + c1;
      t  = (f0 + f1) & mask;
      f0 = f1;
      f1 = t;
      t  = (c0 + c1 > lim) ? lim : c0 + c1;
      c0 = c1;
      c1 = t;
    end
    tv  = m ? cs : c0;
    ovf = (tv > mask);
    res = (ovf && SAT) ? mask : (m ? s : f0);
  endtask

  task automatic drive(input int which, input bit st, input int n, input bit m);
    if (which == 0) begin
      b20.start = st; b20.nth = 8'(n); b20.mode = m;
    end else begin
      b8.start = st;  b8.nth = 4'(n);  b8.mode = m;
    end
  endtask

  task automatic release_start();
    b20.start = 1'b0;
    b8.start  = 1'b0;
  endtask

  // Called at a negedge; lat0 = clock edges already elapsed since accept.
  task automatic wait_done(input int which, input int lat0,
                           output longint res, output bit ovf, output int lat);
    lat = lat0;
    res = -1;
    ovf = 1'b0;
    while (lat < TIMEOUT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (get_oe(which)) begin
        res = get_res(which);
        ovf = get_ovf(which);
        break;
      end
    end
  endtask

  task automatic run_req(input int which, input int n, input bit m,
                         output longint res, output bit ovf, output int lat);
    @(negedge clk);
    drive(which, 1'b1, n, m);
    @(posedge clk);          // accept edge E0
    @(negedge clk);
    release_start();
    wait_done(which, 0, res, ovf, lat);
  endtask

  vec_t   vecs[$];
  longint r, er;
  bit     o, eo;
  int     lat, seen;

  initial begin
    vecs.push_back('{0, 10, 1'b0, 55,      1'b0, 11});
    vecs.push_back('{0, 10, 1'b1, 143,     1'b0, 11});
    vecs.push_back('{0, 1,  1'b1, 1,       1'b0, 2});
    vecs.push_back('{0, 5,  1'b1, 12,      1'b0, 6});
    vecs.push_back('{0, 5,  1'b0, 5,       1'b0, 6});
    vecs.push_back('{0, 0,  1'b0, 0,       1'b0, 1});
    vecs.push_back('{0, 0,  1'b1, 0,       1'b0, 1});
    vecs.push_back('{0, 30, 1'b0, 832040,  1'b0, 31});
    vecs.push_back('{0, 31, 1'b0, SAT ? 1048575 : 297693, 1'b1, 32});
    vecs.push_back('{0, 29, 1'b1, SAT ? 1048575 : 297692, 1'b1, 30});
    vecs.push_back('{0, 28, 1'b1, 832039,  1'b0, 29});
    vecs.push_back('{1, 13, 1'b0, 233,     1'b0, 14});
    vecs.push_back('{1, 14, 1'b0, SAT ? 255 : 121, 1'b1, 15});

    reset = 1'b1;
    drive(0, 1'b0, 0, 1'b0);
    drive(1, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst_busy%0d", w),   get_busy(w), 0);
      check($sformatf("rst_result%0d", w), get_res(w),  0);
      check($sformatf("rst_out_en%0d", w), get_oe(w),   0);
      check($sformatf("rst_ovf%0d", w),    get_ovf(w),  0);
    end

    // Table-driven directed requests.
    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].which, vecs[i].n, vecs[i].m, r, o, lat);
      check($sformatf("row%0d_n%0d_result", i, vecs[i].n), r,   vecs[i].res);
      check($sformatf("row%0d_n%0d_ovf", i, vecs[i].n),    o,   vecs[i].ovf);
      check($sformatf("row%0d_n%0d_latency", i, vecs[i].n), lat, vecs[i].lat);
      check($sformatf("row%0d_busy_low_at_done", i), get_busy(vecs[i].which), 0);
      @(negedge clk);
      check($sformatf("row%0d_out_en_one_cycle", i), get_oe(vecs[i].which), 0);
    end

    // start pulsed with a different nth while busy must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    release_start();
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 3, 1'b0);
    @(negedge clk);
    release_start();
    wait_done(0, 4, r, o, lat);
    check("collide_result",  r,   55);
    check("collide_latency", lat, 11);

    // start held high through completion: next accept at E(n+2).
    @(negedge clk);
    drive(0, 1'b1, 10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    wait_done(0, 0, r, o, lat);
    check("held_first_latency", lat, 11);
    check("held_busy_at_done",  b20.busy, 0);
    @(posedge clk);
    @(negedge clk);
    check("held_busy_after_next_edge", b20.busy, 1);
    release_start();
    wait_done(0, 0, r, o, lat);
    check("held_second_result",  r,   55);
    check("held_second_latency", lat, 11);

    // Reset in the middle of a request.
    @(negedge clk);
    drive(0, 1'b1, 20, 1'b0);
    @(posedge clk);
    @(negedge clk);
    release_start();
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy",   b20.busy,     0);
    check("midrst_result", b20.result,   0);
    check("midrst_out_en", b20.out_en,   0);
    check("midrst_ovf",    b20.overflow, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (b20.out_en) seen++;
    end
    check("midrst_no_out_en", seen, 0);
    run_req(0, 6, 1'b0, r, o, lat);
    check("post_rst_result",  r,   8);
    check("post_rst_latency", lat, 7);

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      int which, n;
      bit m;
      which = int'($urandom_range(0, 1));
      n     = (which == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 15));
      if (i % 8 == 0 && which == 0) n = int'($urandom_range(0, 255));
      m     = 1'($urandom_range(0, 1));
      ref_model((which == 0) ? 20 : 8, n, m, er, eo);
      run_req(which, n, m, r, o, lat);
      check($sformatf("rnd%0d_w%0d_n%0d_m%0d_result", i, which, n, m), r, er);
      check($sformatf("rnd%0d_w%0d_n%0d_m%0d_ovf", i, which, n, m), o, eo);
      check($sformatf("rnd%0d_latency", i), lat, n + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
